// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame format,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;
  localparam int OVERSAMPLE      = 16;
  // Tick counter width covers stop lengths up to 2 bits (SB_TICK <= 32).
  localparam int S_WIDTH         = 5;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per request, LSB first, framed by a
// start bit and SB_TICK/16 stop bits, paced by a 16x oversampling tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk_100MHz,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [S_WIDTH-1:0] S_LAST  = S_WIDTH'(OVERSAMPLE - 1);
  localparam logic [S_WIDTH-1:0] SB_LAST = S_WIDTH'(SB_TICK - 1);
  localparam logic [NW-1:0]      N_LAST  = NW'(DBIT - 1);

  state_t              state_r, state_s;
  logic [S_WIDTH-1:0]  s_r, s_s;
  logic [NW-1:0]       n_r, n_s;
  logic [DBIT-1:0]     b_r, b_s;
  logic                tx_r, tx_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_r <= IDLE;
      s_r     <= '0;
      n_r     <= '0;
      b_r     <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      s_r     <= s_s;
      n_r     <= n_s;
      b_r     <= b_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic; outputs derive from the next state so they register glitch-free.
  always_comb begin
    state_s = state_r;
    s_s     = s_r;
    n_s     = n_r;
    b_s     = b_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_start) begin
          b_s     = din;
          s_s     = '0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_r == S_LAST) begin
            s_s     = '0;
            n_s     = '0;
            state_s = DATA;
          end else begin
            s_s = s_r + 1'b1;
          end
        end else begin
          s_s = s_r;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_r == S_LAST) begin
            s_s = '0;
            b_s = b_r >> 1;
            if (n_r == N_LAST) begin
              state_s = STOP;
            end else begin
              n_s = n_r + 1'b1;
            end
          end else begin
            s_s = s_r + 1'b1;
          end
        end else begin
          s_s = s_r;
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_r == SB_LAST) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            s_s = s_r + 1'b1;
          end
        end else begin
          s_s = s_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    tx_s = 1'b1;
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = b_s[0];
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);
  end

  assign tx           = tx_r;
  assign tx_busy      = busy_r;
  assign tx_done_tick = done_r;

endmodule
